div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit. Sits directly downstream of the register file: takes ReadData1/ReadData2 as dividend/divisor and returns the quotient or remainder, plus destination register, on the register-file write path.
- Used for DIV/DIVU/REM/REMU in place of single-cycle ALU results; the core stalls while Busy is high.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- DIR_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- Start  in  1  request; sampled only in IDLE.
- Op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Operand1  in  XLEN  dividend (rs1 data).
- Operand2  in  XLEN  divisor (rs2 data).
- RdIn  in  DIR_W  destination register of the request.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse; Result/RdOut valid.
- Result  out  XLEN  quotient or remainder.
- RdOut  out  DIR_W  destination register, captured at accept.
- WriteEn  out  1  equals Done && RdOut != 0; drives register-file WriteEn.

Behaviour:
- Reset (rst=0, async): state=IDLE, Busy=0, Done=0, WriteEn=0, Result=0, RdOut=0, internal counter/registers=0. Reset mid-division aborts the division with no Done pulse. After release, the block is in IDLE and accepts Start on the next edge.
- States: IDLE, CALC, FIX, DONE.
- IDLE, Start=1 at edge E0:
  - Latch Op, RdIn, operands.
  - Signed ops (DIV/REM): store |Operand1| and |Operand2|; record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
  - Special cases go directly to DONE at E0, so Done is visible after E0 (latency 1):
    - divisor==0: quotient = 0xFFFFFFFF; remainder = Operand1 (unmodified).
    - DIV/REM with Operand1=0x80000000 and Operand2=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Otherwise go to CALC with counter=0.
- CALC, edges E1..E32, one iteration per edge:
  - Shift {rem,quot} left by 1.
  - Trial subtract: 33-bit rem − divisor.
  - If the result is non-negative, keep the difference and set quotient LSB = 1.
  - counter++. At E32 (counter reaches 32) go to FIX.
- FIX, edge E33:
  - Apply sign correction (two's-complement negate where the stored sign is 1).
  - Select quotient for DIV/DIVU, remainder for REM/REMU.
  - Register Result; go to DONE.
- DONE: Done=1 for exactly one cycle (visible after E33, i.e. 34 edges after accept); next edge goes to IDLE.
- Result and RdOut hold their values after Done until the next accept or reset.
- Start is ignored in CALC/FIX/DONE; no queuing. Start may be accepted again on the first edge back in IDLE.
- Operand, Op and RdIn changes after E0 have no effect on the request in flight.
- Unsigned ops use raw operands; no sign correction.
- Zero remainder is never negated. Zero quotient is never negated.
- Division of 0 by nonzero takes the normal 34-cycle path and yields 0/0.

Test Plan:
- Reset, then DIVU 100/7 with RdIn=5 -> Busy high for 34 cycles; Done pulses once; Result=14, RdOut=5, WriteEn=1.
- REMU 100/7 -> Result=2. DIV -7/2 (0xFFFFFFF9, 2) -> Result=0xFFFFFFFD (-3). REM -7/2 -> Result=0xFFFFFFFF (-1). REM 7/-2 -> Result=1.
- Divide by zero, DIVU 0x1234/0 -> Done one edge after accept; Result=0xFFFFFFFF. REMU 0x1234/0 -> Result=0x1234.
- Overflow, DIV 0x80000000/0xFFFFFFFF -> 1-cycle Done, Result=0x80000000. REM of the same operands -> Result=0.
- Start pulsed at cycle 10 of a running DIVU 50/5, with different operands -> ignored; Result=10; exactly one Done. Start held high continuously -> back-to-back ops, each 34 cycles.
- rst asserted at iteration 16, then released -> no Done; Busy=0 immediately; next DIVU 9/3 -> Result=3. RdIn=0 -> Done=1, WriteEn=0.

Source files
------------

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per clock. Divide-by-zero
// and signed overflow complete one edge after accept. Every other request
// takes 34 edges from accept to the Done pulse.
//
// Handshake: Start is sampled only while the unit is idle (Busy low); the
// request is accepted on that edge. Start is ignored while Busy is high and
// is never queued. Done is a one-cycle pulse, and Result/RdOut are valid
// while it is high. They hold their values until the next result or reset.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int DIR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [XLEN-1:0]  Operand1,
    input  logic [XLEN-1:0]  Operand2,
    input  logic [DIR_W-1:0] RdIn,
    output logic             Busy,
    output logic             Done,
    output logic [XLEN-1:0]  Result,
    output logic [DIR_W-1:0] RdOut,
    output logic             WriteEn,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_q, state_d;
    logic [5:0]       counter_q, counter_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             sel_rem_q, sel_rem_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [DIR_W-1:0] rd_q, rd_d;

    // One restoring step: bring the next dividend bit into the partial
    // remainder, then try to subtract the divisor. The partial remainder is
    // always below the divisor, so 33 bits are enough for the shifted value.
    logic [XLEN:0] trial_shift;
    logic [XLEN:0] trial_diff;
    assign trial_shift = {rem_q, quot_q[XLEN-1]};
    assign trial_diff  = trial_shift - {1'b0, divisor_q};

    // Operand magnitudes at accept. Unsigned ops pass the raw operands.
    // The magnitude of INT_MIN is INT_MIN read as unsigned, which is correct.
    logic signed_op;
    logic [XLEN-1:0] abs1, abs2;
    assign signed_op = ~Op[0];
    assign abs1 = (signed_op && Operand1[XLEN-1]) ? (~Operand1 + 1'b1) : Operand1;
    assign abs2 = (signed_op && Operand2[XLEN-1]) ? (~Operand2 + 1'b1) : Operand2;

    // Sign-corrected results of the iteration. Negating zero gives zero,
    // so a zero quotient or remainder is never turned negative.
    logic [XLEN-1:0] quot_fix, rem_fix;
    assign quot_fix = q_neg_q ? (~quot_q + 1'b1) : quot_q;
    assign rem_fix  = r_neg_q ? (~rem_q + 1'b1) : rem_q;

    // Next-state and datapath updates for the divider FSM.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;
        rd_d      = rd_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    sel_rem_d = Op[1];
                    rd_d      = RdIn;
                    counter_d = '0;
                    rem_d     = '0;
                    quot_d    = abs1;
                    divisor_d = abs2;
                    q_neg_d   = signed_op & (Operand1[XLEN-1] ^ Operand2[XLEN-1]);
                    r_neg_d   = signed_op & Operand1[XLEN-1];
                    if (Operand2 == '0) begin
                        result_d = Op[1] ? Operand1 : '1;
                        state_d  = S_DONE;
                    end else if (signed_op && (Operand1 == INT_MIN) && (Operand2 == '1)) begin
                        result_d = Op[1] ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!trial_diff[XLEN]) begin
                    rem_d  = trial_diff[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = trial_shift[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end
                counter_d = counter_q + 6'd1;
                if (counter_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = sel_rem_q ? rem_fix : quot_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Result    = result_q;
    assign RdOut     = rd_q;
    assign WriteEn   = Done && (rd_q != '0);
    assign dbg_state = state_q;

endmodule
